// File: rtl/regs_pkg.sv
// Shared definitions for the 8 x 16-bit register file, its datapath and the
// read-side scanner (leitor_registradores).
package regs_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned NUM_REGS = 8;
    // Range length counter must hold 1..NUM_REGS.
    localparam int unsigned CNT_W    = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_e;

    // Inclusive range length ((last - first) mod NUM_REGS) + 1; the ADDR_W-bit
    // subtraction wraps naturally through 7 -> 0.
    function automatic logic [CNT_W-1:0] range_len(input logic [ADDR_W-1:0] first,
                                                   input logic [ADDR_W-1:0] last);
        logic [ADDR_W-1:0] span;
        span = last - first;
        return CNT_W'(span) + CNT_W'(1);
    endfunction

endpackage

// File: rtl/leitor_registradores.sv
// leitor_registradores: sequential read-side scanner for the register file.
// On start it walks the inclusive range firstReg..lastReg (wrapping 7->0)
// through one read port and streams each value on a valid/ready interface.
// Optional feature macro: LEITOR_REGISTRADORES_CHECKSUM_EN appends an XOR
// checksum word (out_chk=1) after the last register word.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   start, abort         scan request (idle only) / cancel active scan
//   firstReg, lastReg    inclusive register range
//   readReg, readData    register file read port (combinational data)
//   out_valid/out_ready  stream handshake
//   out_data, out_idx    word and its register index
//   out_last, out_chk    final word / checksum word flags
//   busy, done           not idle / one-cycle completion pulse
module leitor_registradores
    import regs_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] firstReg,
    input  logic [ADDR_W-1:0] lastReg,
    output logic [ADDR_W-1:0] readReg,
    input  logic [DATA_W-1:0] readData,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_idx,
    output logic              out_last,
    output logic              out_chk,
    output logic              busy,
    output logic              done
);

    scan_state_e       state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_idx_q, out_idx_d;
    logic              out_last_q, out_last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              hs;
    logic              chk_pending;

`ifdef LEITOR_REGISTRADORES_CHECKSUM_EN
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              chk_pend_q, chk_pend_d;
    logic              out_chk_q, out_chk_d;

    assign chk_pending = chk_pend_q;
    assign out_chk     = out_chk_q;
`else
    assign chk_pending = 1'b0;
    assign out_chk     = 1'b0;
`endif

    assign readReg   = ptr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            remaining_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

`ifdef LEITOR_REGISTRADORES_CHECKSUM_EN
    // Checksum accumulator and checksum-word bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            chk_pend_q <= 1'b0;
            out_chk_q  <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            chk_pend_q <= chk_pend_d;
            out_chk_q  <= out_chk_d;
        end
    end
`endif

    // Next-state and output-register logic.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
`ifdef LEITOR_REGISTRADORES_CHECKSUM_EN
        acc_d       = acc_q;
        chk_pend_d  = chk_pend_q;
        out_chk_d   = out_chk_q;
`endif
        hs          = out_valid_q && out_ready;

        case (state_q)
            IDLE: begin
                if (start) begin
                    ptr_d       = firstReg;
                    remaining_d = range_len(firstReg, lastReg);
                    state_d     = SCAN;
`ifdef LEITOR_REGISTRADORES_CHECKSUM_EN
                    acc_d       = '0;
                    chk_pend_d  = 1'b1;
`endif
                end
            end
            SCAN: begin
                // Abort drops any presented word and skips the done pulse.
                if (abort) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    if (remaining_q != '0 && (!out_valid_q || out_ready)) begin
                        out_data_d  = readData;
                        out_idx_d   = ptr_q;
                        out_valid_d = 1'b1;
`ifdef LEITOR_REGISTRADORES_CHECKSUM_EN
                        // The checksum word carries out_last instead.
                        out_last_d  = 1'b0;
                        out_chk_d   = 1'b0;
                        acc_d       = acc_q ^ readData;
`else
                        out_last_d  = (remaining_q == CNT_W'(1));
`endif
                        ptr_d       = ptr_q + ADDR_W'(1);
                        remaining_d = remaining_q - CNT_W'(1);
                    end
`ifdef LEITOR_REGISTRADORES_CHECKSUM_EN
                    else if (chk_pend_q && (!out_valid_q || out_ready)) begin
                        out_data_d  = acc_q;
                        out_idx_d   = '0;
                        out_valid_d = 1'b1;
                        out_last_d  = 1'b1;
                        out_chk_d   = 1'b1;
                        chk_pend_d  = 1'b0;
                    end
`endif
                    else if (hs) begin
                        out_valid_d = 1'b0;
                    end

                    // Final word accepted: nothing left to load.
                    if (remaining_q == '0 && !chk_pending && hs) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

endmodule

// File: tb/tb_leitor_registradores.sv
// Directed self-checking bench for leitor_registradores with a small
// behavioural register file (R0 reads zero, writes at the clock edge).
module tb_leitor_registradores;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [2:0]  firstReg;
    logic [2:0]  lastReg;
    logic [2:0]  readReg;
    logic [15:0] readData;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  out_idx;
    logic        out_last;
    logic        out_chk;
    logic        busy;
    logic        done;

    logic [15:0] rf [8];
    logic        rf_clr;
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;

    int errors;
    int checks;

    leitor_registradores dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .firstReg  (firstReg),
        .lastReg   (lastReg),
        .readReg   (readReg),
        .readData  (readData),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_chk   (out_chk),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 8; i++) rf[i] <= 16'd0;
        end else if (we && wa != 3'd0) begin
            rf[wa] <= wd;
        end
    end

    assign readData = (readReg == 3'd0) ? 16'd0 : rf[readReg];

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        we = 1'b1; wa = a; wd = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    // Returns at the negedge of the cycle after the start edge.
    task automatic start_scan(input logic [2:0] f, input logic [2:0] l);
        @(negedge clk);
        firstReg = f; lastReg = l; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; rf_clr = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({readReg, out_valid, out_data, out_idx, out_last, out_chk, busy, done} !== 26'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rd=%0d v=%b d=%0d i=%0d l=%b c=%b busy=%b done=%b, want all 0",
                     readReg, out_valid, out_data, out_idx, out_last, out_chk, busy, done);
        end
        rf_clr = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_idle: got busy=%b v=%b, want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_fill;
        logic [15:0] ed;
        logic        el;
        wr(3'd1, 16'd5);
        wr(3'd2, 16'd10);
        wr(3'd0, 16'd99);
        out_ready = 1'b1;
        start_scan(3'd0, 3'd7);
        checks++;
        if (readReg !== 3'd0 || out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL fill_k1: got rd=%0d v=%b busy=%b, want 0 0 1", readReg, out_valid, busy);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ed = (i == 1) ? 16'd5 : (i == 2) ? 16'd10 : 16'd0;
`ifdef LEITOR_REGISTRADORES_CHECKSUM_EN
            el = 1'b0;
`else
            el = (i == 7);
`endif
            checks++;
            if (out_valid !== 1'b1 || out_idx !== 3'(i) || out_data !== ed || out_last !== el
                || out_chk !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL fill_word%0d: got v=%b i=%0d d=%0d l=%b c=%b done=%b, want v=1 i=%0d d=%0d l=%b c=0 done=0",
                         i, out_valid, out_idx, out_data, out_last, out_chk, done, i, ed, el);
            end
        end
`ifdef LEITOR_REGISTRADORES_CHECKSUM_EN
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'd15 || out_idx !== 3'd0 || out_chk !== 1'b1 || out_last !== 1'b1) begin
            errors++;
            $display("FAIL fill_chk: got v=%b d=%0d i=%0d c=%b l=%b, want 1 15 0 1 1",
                     out_valid, out_data, out_idx, out_chk, out_last);
        end
`endif
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL fill_done: got done=%b v=%b, want 1 0", done, out_valid);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL fill_idle: got done=%b busy=%b, want 0 0", done, busy);
        end
    endtask

    task automatic test_wrap;
        logic [2:0]  ei;
        logic [15:0] ed;
        logic        el;
        out_ready = 1'b1;
        start_scan(3'd6, 3'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ei = 3'(6 + i);
            ed = (ei == 3'd1) ? 16'd5 : 16'd0;
`ifdef LEITOR_REGISTRADORES_CHECKSUM_EN
            el = 1'b0;
`else
            el = (i == 3);
`endif
            checks++;
            if (out_valid !== 1'b1 || out_idx !== ei || out_data !== ed || out_last !== el) begin
                errors++;
                $display("FAIL wrap_word%0d: got v=%b i=%0d d=%0d l=%b, want v=1 i=%0d d=%0d l=%b",
                         i, out_valid, out_idx, out_data, out_last, ei, ed, el);
            end
        end
`ifdef LEITOR_REGISTRADORES_CHECKSUM_EN
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'd5 || out_chk !== 1'b1 || out_last !== 1'b1) begin
            errors++;
            $display("FAIL wrap_chk: got v=%b d=%0d c=%b l=%b, want 1 5 1 1", out_valid, out_data, out_chk, out_last);
        end
`endif
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL wrap_done: got %b, want 1", done);
        end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        start_scan(3'd1, 3'd2);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'd5 || out_idx !== 3'd1) begin
            errors++;
            $display("FAIL bp_first: got v=%b d=%0d i=%0d, want 1 5 1", out_valid, out_data, out_idx);
        end
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'd5 || out_idx !== 3'd1 || out_last !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%b d=%0d i=%0d l=%b, want 1 5 1 0",
                         j, out_valid, out_data, out_idx, out_last);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
`ifdef LEITOR_REGISTRADORES_CHECKSUM_EN
        if (out_valid !== 1'b1 || out_data !== 16'd10 || out_idx !== 3'd2 || out_last !== 1'b0) begin
`else
        if (out_valid !== 1'b1 || out_data !== 16'd10 || out_idx !== 3'd2 || out_last !== 1'b1) begin
`endif
            errors++;
            $display("FAIL bp_second: got v=%b d=%0d i=%0d l=%b, want v=1 d=10 i=2", out_valid, out_data, out_idx, out_last);
        end
`ifdef LEITOR_REGISTRADORES_CHECKSUM_EN
        @(negedge clk);
        checks++;
        if (out_data !== 16'd15 || out_chk !== 1'b1) begin
            errors++;
            $display("FAIL bp_chk: got d=%0d c=%b, want 15 1", out_data, out_chk);
        end
`endif
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_done: got done=%b v=%b, want 1 0", done, out_valid);
        end
    endtask

    task automatic test_abort;
        out_ready = 1'b1;
        start_scan(3'd0, 3'd7);
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 3'd2 || out_data !== 16'd10) begin
            errors++;
            $display("FAIL abort_third: got v=%b i=%0d d=%0d, want 1 2 10", out_valid, out_idx, out_data);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_stop: got v=%b busy=%b done=%b, want 0 0 0", out_valid, busy, done);
        end
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet%0d: got done=%b v=%b, want 0 0", j, done, out_valid);
            end
        end
        start_scan(3'd2, 3'd2);
        @(negedge clk);
        checks++;
`ifdef LEITOR_REGISTRADORES_CHECKSUM_EN
        if (out_valid !== 1'b1 || out_idx !== 3'd2 || out_data !== 16'd10 || out_last !== 1'b0) begin
`else
        if (out_valid !== 1'b1 || out_idx !== 3'd2 || out_data !== 16'd10 || out_last !== 1'b1) begin
`endif
            errors++;
            $display("FAIL abort_restart: got v=%b i=%0d d=%0d l=%b, want v=1 i=2 d=10", out_valid, out_idx, out_data, out_last);
        end
`ifdef LEITOR_REGISTRADORES_CHECKSUM_EN
        @(negedge clk);
`endif
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL abort_restart_done: got %b, want 1", done);
        end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b1;
        start_scan(3'd0, 3'd7);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({readReg, out_valid, out_data, out_idx, out_last, out_chk, busy, done} !== 26'd0) begin
            errors++;
            $display("FAIL reset_mid: got rd=%0d v=%b d=%0d i=%0d l=%b c=%b busy=%b done=%b, want all 0",
                     readReg, out_valid, out_data, out_idx, out_last, out_chk, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start_scan(3'd1, 3'd1);
        checks++;
        if (readReg !== 3'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_start: got rd=%0d busy=%b, want 1 1", readReg, busy);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 3'd1 || out_data !== 16'd5) begin
            errors++;
            $display("FAIL reset_mid_word: got v=%b i=%0d d=%0d, want 1 1 5", out_valid, out_idx, out_data);
        end
`ifdef LEITOR_REGISTRADORES_CHECKSUM_EN
        @(negedge clk);
`endif
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_done: got %b, want 1", done);
        end
    endtask

`ifdef LEITOR_REGISTRADORES_CHECKSUM_EN
    task automatic test_checksum;
        out_ready = 1'b1;
        start_scan(3'd1, 3'd2);
        @(negedge clk);
        checks++;
        if (out_data !== 16'd5 || out_chk !== 1'b0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL chk_w0: got d=%0d c=%b l=%b, want 5 0 0", out_data, out_chk, out_last);
        end
        @(negedge clk);
        checks++;
        if (out_data !== 16'd10 || out_chk !== 1'b0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL chk_w1: got d=%0d c=%b l=%b, want 10 0 0", out_data, out_chk, out_last);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'd15 || out_idx !== 3'd0 || out_chk !== 1'b1 || out_last !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL chk_word: got v=%b d=%0d i=%0d c=%b l=%b done=%b, want 1 15 0 1 1 0",
                     out_valid, out_data, out_idx, out_chk, out_last, done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL chk_done: got %b, want 1", done);
        end
    endtask
`endif

    initial begin
        errors = 0; checks = 0;
        start = 1'b0; abort = 1'b0; firstReg = 3'd0; lastReg = 3'd0;
        out_ready = 1'b0; we = 1'b0; wa = 3'd0; wd = 16'd0;
        rf_clr = 1'b1; rst_n = 1'b0;
        test_reset();
        test_fill();
        test_wrap();
        test_backpressure();
        test_abort();
        test_reset_mid();
`ifdef LEITOR_REGISTRADORES_CHECKSUM_EN
        test_checksum();
`endif
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/leitor_registradores.md
Name: leitor_registradores

Overview:
- Sequential read-side scanner for the 8 x 16-bit register file; R0 is hardwired to zero.
- On a start pulse it walks an inclusive register range through one register-file read port.
- Each value is streamed out on a valid/ready interface.
- Used for debug dump and architectural-state checking next to the datapath; it never writes the register file.

Parameters:
DATA_W, 16, register data width
ADDR_W, 3, register address width (number of registers = 2**ADDR_W = 8)

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  one-cycle request to begin a scan; ignored unless idle
abort  input  1  cancels an active scan
firstReg  input  ADDR_W  first register of the range
lastReg  input  ADDR_W  last register of the range, inclusive
readReg  output  ADDR_W  address driven to the register file read port
readData  input  DATA_W  combinational read data returned by the register file
out_valid  output  1  out_data/out_idx hold a word
out_ready  input  1  consumer accepts the word this cycle
out_data  output  DATA_W  register value, or checksum word
out_idx  output  ADDR_W  register index of out_data
out_last  output  1  final word of the scan
out_chk  output  1  current word is the checksum word (0 when feature is off)
busy  output  1  state != IDLE
done  output  1  one-cycle pulse at normal completion

Behaviour:
- Reset (rst_n=0, async): state=IDLE, ptr=0, remaining=0, checksum=0.
- During reset all outputs are 0: readReg, out_*, busy, done.
- States: IDLE, SCAN, DONE.
- IDLE:
  - start=1 at an edge sets ptr<=firstReg.
  - remaining<=((lastReg-firstReg) mod 8)+1, as a 4-bit value in 1..8.
  - Next state is SCAN.
  - firstReg>lastReg wraps through 7->0. firstReg==lastReg scans one register.
- readReg = ptr at all times.
- SCAN:
  - load = (remaining!=0) && (!out_valid || out_ready).
  - On load:
    - out_data<=readData, out_idx<=ptr, out_valid<=1.
    - out_last<=(remaining==1), out_chk<=0.
    - ptr<=ptr+1 (mod 8), remaining<=remaining-1.
  - Handshake completes (out_valid && out_ready) with no load: out_valid<=0.
  - remaining==0 and the last word handshakes: next state DONE.
  - out_data, out_idx and out_last are stable while out_valid=1 and out_ready=0.
- Throughput is one word per cycle with out_ready held high.
- Latency:
  - start sampled at edge k: readReg=firstReg during cycle k+1, first out_valid in cycle k+2.
  - 8-register dump with ready high: words in cycles k+2..k+9, done=1 in cycle k+10.
- DONE: done=1 for one cycle, then IDLE. busy=0 in IDLE only.
- abort in SCAN takes priority over load and handshake:
  - out_valid<=0, state<=IDLE, no done pulse.
  - A word presented in the same cycle counts as not transferred.
- start while busy: ignored.
- Register write to the register currently addressed in the same cycle: the old value is captured, because the register file updates at the edge.
- R0 always reads 0; nothing is filtered.

Optional Feature:
- Macro: LEITOR_REGISTRADORES_CHECKSUM_EN.
- Enabled:
  - A 16-bit XOR accumulator is cleared on start and XORs each loaded register word.
  - After the last register word, one extra word is emitted: out_data=checksum, out_idx=0, out_chk=1, out_last=1.
  - The register word before it has out_last=0.
  - It obeys the same handshake; done follows its handshake (8-register scan: done in cycle k+11).
- Disabled: no accumulator, out_chk tied 0, behaviour as above.

Decomposition:
- Package regs_pkg holds:
  - DATA_W=16, ADDR_W=3, NUM_REGS=8.
  - State enum {IDLE, SCAN, DONE}.
  - The range-length function ((last-first) mod NUM_REGS)+1.
- Shared with the register file and datapath.
- No sub-module: single FSM plus output register. The checksum accumulator stays inline under the macro.

Test Plan:
- Fill registers:
  - Stimulus: write R1=5, R2=10, attempted R0=99. Dump first=0, last=7, out_ready=1.
  - Required: idx 0..7 with data 0,5,10,0,0,0,0,0; out_last only on idx 7; done at k+10.
- Wrap:
  - Stimulus: first=6, last=1.
  - Required: idx sequence 6,7,0,1; remaining starts at 4; out_last on idx 1.
- Backpressure:
  - Stimulus: first=1, last=2, out_ready low for 3 cycles after first valid.
  - Required: out_data=5/out_idx=1 held stable, then 10/idx 2, no loss or duplication.
- Abort mid-scan:
  - Stimulus: abort in the cycle the 3rd word is valid.
  - Required: out_valid=0 next cycle, busy=0, done never pulses; a following start is accepted.
- Reset mid-scan:
  - Stimulus: rst_n low asynchronously between edges.
  - Required: all outputs 0 immediately; start after release begins a clean scan.
- Checksum (macro on):
  - Stimulus: first=1, last=2.
  - Required: words 5, 10, then checksum 15 with out_chk=1, out_last=1, done after its handshake.
